input_pair_parser: RTL and testbench

//  Ingress end of the byte-stream arithmetic path. Consumes the raw host byte stream
//  (PCIe/Avalon write side), pairs bytes into operands A/B for the arithmetic unit,

---
 rtl/input_pair_parser_pkg.sv | 12 +
 rtl/input_pair_parser_if.sv | 26 ++
 rtl/input_pair_parser.sv | 103 ++++++++++
 tb/tb_input_pair_parser.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/input_pair_parser_pkg.sv
// Shared stream-path definitions: the end-of-stream marker and the parser state encoding.
// The egress output stage imports the same package to turn stop tokens back into STOPBYTE.
package stream_pkg;

  localparam logic [7:0] STOPBYTE = 8'h12;

  typedef enum logic [0:0] {
    WAIT_A,
    WAIT_B
  } parse_state_t;

endpackage

// File: rtl/input_pair_parser_if.sv
// Byte ingress and operand-pair egress signals of the pair parser.
// The master side is the host plus the arithmetic unit; the slave side is the parser.
interface input_pair_parser_if #(
  parameter int CNT_W = 16
);
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       op_a;
  logic [7:0]       op_b;
  logic             data_select;
  logic             op_valid;
  logic             op_ready;
  logic             frame_err;
  logic [CNT_W-1:0] pair_count;

  modport master (
    output in_data, in_valid, op_ready,
    input  in_ready, op_a, op_b, data_select, op_valid, frame_err, pair_count
  );

  modport slave (
    input  in_data, in_valid, op_ready,
    output in_ready, op_a, op_b, data_select, op_valid, frame_err, pair_count
  );
endinterface

// File: rtl/input_pair_parser.sv
// Pairs ingress bytes into A/B operands and forwards STOPBYTE (A position only) as a
// data_select=0 token. A half-built pair is dropped after TIMEOUT_CYC idle cycles.
module input_pair_parser
  import stream_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 16
) (
  input logic               clk,
  input logic               n_rst,
  input_pair_parser_if.slave bus
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(TIMEOUT_CYC - 1);

  parse_state_t     state;
  logic [7:0]       a_q;
  logic [TMR_W-1:0] timer;
  logic [7:0]       op_a;
  logic [7:0]       op_b;
  logic             data_select;
  logic             op_valid;
  logic             frame_err;
  logic [CNT_W-1:0] pair_count;
  logic             in_ready;
  logic             accept;
  logic             out_hs;

  // One-entry output register: room exists when empty or being drained this cycle.
  assign in_ready = !op_valid || bus.op_ready;
  assign accept   = bus.in_valid && in_ready;
  assign out_hs   = op_valid && bus.op_ready;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= WAIT_A;
      a_q         <= '0;
      timer       <= '0;
      op_a        <= '0;
      op_b        <= '0;
      data_select <= 1'b0;
      op_valid    <= 1'b0;
      frame_err   <= 1'b0;
      pair_count  <= '0;
    end else begin
      frame_err <= 1'b0;

      // A stop-token handshake clears the count; a load below may re-set op_valid.
      if (out_hs) begin
        op_valid <= 1'b0;
        if (data_select) pair_count <= pair_count + CNT_W'(1);
        else             pair_count <= '0;
      end

      case (state)
        WAIT_A: begin
          if (accept) begin
            if (bus.in_data == STOPBYTE) begin
              op_a        <= '0;
              op_b        <= '0;
              data_select <= 1'b0;
              op_valid    <= 1'b1;
            end else begin
              a_q   <= bus.in_data;
              timer <= '0;
              state <= WAIT_B;
            end
          end
        end

        WAIT_B: begin
          // A byte arriving in the timeout cycle still completes the pair.
          if (accept) begin
            op_a        <= a_q;
            op_b        <= bus.in_data;
            data_select <= 1'b1;
            op_valid    <= 1'b1;
            state       <= WAIT_A;
          end else if (timer == TIMER_LAST) begin
            frame_err <= 1'b1;
            a_q       <= '0;
            timer     <= '0;
            state     <= WAIT_A;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end

        default: state <= WAIT_A;
      endcase
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.op_a        = op_a;
  assign bus.op_b        = op_b;
  assign bus.data_select = data_select;
  assign bus.op_valid    = op_valid;
  assign bus.frame_err   = frame_err;
  assign bus.pair_count  = pair_count;

endmodule

// File: tb/tb_input_pair_parser.sv
// Directed self-checking bench for input_pair_parser: a byte-stream vector table plus
// hand-written sequences for reset, back-pressure and the timeout boundary.
module tb_input_pair_parser;

  localparam int TIMEOUT_CYC = 255;
  localparam int CNT_W       = 16;

  logic clk;
  logic n_rst;
  int   checks;
  int   failures;

  input_pair_parser_if #(.CNT_W(CNT_W)) bus ();

  input_pair_parser #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .CNT_W      (CNT_W)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic       exp_valid;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    logic       exp_ds;
    int         exp_count;
  } vec_t;

  vec_t vecs[14];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Present one byte at a negedge, hold until accepted, return at the following negedge.
  task automatic applyStimulus(input logic [7:0] b);
    bit done;
    done        = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      if (bus.in_ready) done = 1;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic doReset();
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic checkPair(input string name, input logic [7:0] a, input logic [7:0] b);
    checkOutput({name, "_valid"}, 32'(bus.op_valid), 32'd1);
    checkOutput({name, "_ds"}, 32'(bus.data_select), 32'd1);
    checkOutput({name, "_a"}, 32'(bus.op_a), 32'(a));
    checkOutput({name, "_b"}, 32'(bus.op_b), 32'(b));
  endtask

  int pulses;
  int pulse_at;

  initial begin
    checks       = 0;
    failures     = 0;
    n_rst        = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    bus.op_ready = 1'b1;

    // {valid, byte, exp_valid, exp_a, exp_b, exp_ds, exp_count} after each clock
    vecs[0]  = '{1'b1, 8'h03, 1'b0, 8'h00, 8'h00, 1'b0, 0};
    vecs[1]  = '{1'b1, 8'h04, 1'b1, 8'h03, 8'h04, 1'b1, 0};
    vecs[2]  = '{1'b1, 8'h12, 1'b1, 8'h00, 8'h00, 1'b0, 1};
    vecs[3]  = '{1'b1, 8'h07, 1'b0, 8'h00, 8'h00, 1'b0, 0};
    vecs[4]  = '{1'b1, 8'h12, 1'b1, 8'h07, 8'h12, 1'b1, 0};
    vecs[5]  = '{1'b1, 8'h12, 1'b1, 8'h00, 8'h00, 1'b0, 1};
    vecs[6]  = '{1'b1, 8'h12, 1'b1, 8'h00, 8'h00, 1'b0, 0};
    vecs[7]  = '{1'b1, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b0, 0};
    vecs[8]  = '{1'b1, 8'h00, 1'b1, 8'hFF, 8'h00, 1'b1, 0};
    vecs[9]  = '{1'b1, 8'h01, 1'b0, 8'h00, 8'h00, 1'b0, 1};
    vecs[10] = '{1'b1, 8'h02, 1'b1, 8'h01, 8'h02, 1'b1, 1};
    vecs[11] = '{1'b1, 8'h05, 1'b0, 8'h00, 8'h00, 1'b0, 2};
    vecs[12] = '{1'b1, 8'h06, 1'b1, 8'h05, 8'h06, 1'b1, 2};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 3};

    #1;
    checkOutput("rst_op_valid", 32'(bus.op_valid), 32'd0);
    checkOutput("rst_pair_count", 32'(bus.pair_count), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;

    // Reset mid-pair discards the stored A byte.
    applyStimulus(8'h05);
    n_rst = 1'b0;
    #1;
    checkOutput("midrst_op_a", 32'(bus.op_a), 32'd0);
    checkOutput("midrst_op_b", 32'(bus.op_b), 32'd0);
    checkOutput("midrst_ds", 32'(bus.data_select), 32'd0);
    checkOutput("midrst_op_valid", 32'(bus.op_valid), 32'd0);
    checkOutput("midrst_frame_err", 32'(bus.frame_err), 32'd0);
    checkOutput("midrst_pair_count", 32'(bus.pair_count), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    checkPair("midrst_pair", 8'h01, 8'h02);

    // Back-to-back table with op_ready held high.
    doReset();
    for (int i = 0; i < 14; i++) begin
      checkOutput($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
      bus.in_data  = vecs[i].data;
      bus.in_valid = vecs[i].valid;
      @(negedge clk);
      bus.in_valid = 1'b0;
      checkOutput($sformatf("vec%0d_op_valid", i), 32'(bus.op_valid), 32'(vecs[i].exp_valid));
      checkOutput($sformatf("vec%0d_count", i), 32'(bus.pair_count), 32'(vecs[i].exp_count));
      if (vecs[i].exp_valid) begin
        checkOutput($sformatf("vec%0d_ds", i), 32'(bus.data_select), 32'(vecs[i].exp_ds));
        checkOutput($sformatf("vec%0d_a", i), 32'(bus.op_a), 32'(vecs[i].exp_a));
        checkOutput($sformatf("vec%0d_b", i), 32'(bus.op_b), 32'(vecs[i].exp_b));
      end
    end

    // Output back-pressure: pair held stable, ingress blocked, then released.
    doReset();
    bus.op_ready = 1'b0;
    applyStimulus(8'h10);
    applyStimulus(8'h20);
    bus.in_data  = 8'h30;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("stall%0d_in_ready", i), 32'(bus.in_ready), 32'd0);
      checkPair($sformatf("stall%0d", i), 8'h10, 8'h20);
      @(negedge clk);
    end
    bus.op_ready = 1'b1;
    #1;
    checkOutput("release_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput("release_op_valid", 32'(bus.op_valid), 32'd0);
    checkOutput("release_count", 32'(bus.pair_count), 32'd1);
    applyStimulus(8'h31);
    checkPair("release_pair", 8'h30, 8'h31);

    // Timeout: partial pair dropped after TIMEOUT_CYC idle cycles.
    doReset();
    applyStimulus(8'h09);
    pulses   = 0;
    pulse_at = -1;
    for (int i = 0; i < TIMEOUT_CYC + 5; i++) begin
      @(negedge clk);
      if (bus.op_valid) checkOutput("timeout_no_op_valid", 32'(bus.op_valid), 32'd0);
      if (bus.frame_err) begin
        pulses++;
        if (pulse_at < 0) pulse_at = i;
      end
    end
    checkOutput("timeout_pulses", 32'(pulses), 32'd1);
    checkOutput("timeout_pulse_cycle", 32'(pulse_at), 32'(TIMEOUT_CYC - 1));
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    checkPair("after_timeout_pair", 8'h01, 8'h02);

    // B byte in the very cycle the timeout would fire completes the pair.
    doReset();
    applyStimulus(8'h09);
    pulses = 0;
    for (int i = 0; i < TIMEOUT_CYC - 1; i++) begin
      @(negedge clk);
      if (bus.frame_err) pulses++;
    end
    applyStimulus(8'h0A);
    checkPair("edge_pair", 8'h09, 8'h0A);
    if (bus.frame_err) pulses++;
    @(negedge clk);
    if (bus.frame_err) pulses++;
    checkOutput("edge_no_frame_err", 32'(pulses), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
